// File: rtl/if_fetch.sv
// Instruction fetch initiator with a small in-order fetch buffer.
// Drives a PC stream to a combinational instruction memory, captures
// {pc, inst, exc} per fetch and presents the head entry to decode over
// valid/ready. Downstream redirects flush the buffer and restart fetch.
// Optional address checking (AdEL detection and fetch halt) is enabled by
// defining the macro IF_ADDR_CHECK_EN; the default build has it disabled.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h9fc00000,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned PTR_W    = 1
) (
  input  logic        clk,
  input  logic        resetn,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst,
  output logic        out_exc
);

  localparam logic [PTR_W:0] Full = (PTR_W + 1)'(DEPTH);

  logic [31:0]      pc_q;
  logic [PTR_W:0]   count_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [31:0]      pc_mem   [DEPTH];
  logic [31:0]      inst_mem [DEPTH];

  logic        halted;
  logic        push;
  logic        pop;
  logic [31:0] wr_inst;

  assign imem_addr = pc_q;
  assign out_valid = (count_q != '0);
  assign pop       = out_valid & out_ready;
  // A full buffer can still take a fetch when the head leaves this cycle.
  assign push      = ~redirect_valid & ~halted & ((count_q < Full) | pop);

`ifdef IF_ADDR_CHECK_EN
  logic exc_now;
  logic halted_q;
  logic exc_mem [DEPTH];

  // Only the boot ROM (0x9fc) and kseg0 RAM (0x800) windows are legal.
  assign exc_now = (pc_q[1:0] != 2'b00) |
                   ((pc_q[31:20] != 12'h9fc) & (pc_q[31:20] != 12'h800));
  assign wr_inst = exc_now ? 32'h0 : imem_data;
  assign halted  = halted_q;
  assign out_exc = out_valid & exc_mem[rd_ptr_q];

  // Stop fetching after a faulting entry until redirect or reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      halted_q <= 1'b0;
    end else if (redirect_valid) begin
      halted_q <= 1'b0;
    end else if (push && exc_now) begin
      halted_q <= 1'b1;
    end
  end

  // Exception flag storage alongside the pc/inst fields.
  always_ff @(posedge clk) begin
    if (push) begin
      exc_mem[wr_ptr_q] <= exc_now;
    end
  end
`else
  assign wr_inst = imem_data;
  assign halted  = 1'b0;
  assign out_exc = 1'b0;
`endif

  assign out_pc   = out_valid ? pc_mem[rd_ptr_q]   : 32'h0;
  assign out_inst = out_valid ? inst_mem[rd_ptr_q] : 32'h0;

  // PC, occupancy and pointer control; redirect overrides push/pop.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pc_q     <= RESET_PC;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else if (redirect_valid) begin
      pc_q     <= redirect_pc;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      if (push) begin
        pc_q     <= pc_q + 32'd4;
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_q + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);
    end
  end

  // Entry storage; stale slots are harmless since count gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]   <= pc_q;
      inst_mem[wr_ptr_q] <= wr_inst;
    end
  end

endmodule
